ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/tta_pkg.sv | 19 +
 rtl/ifq_fifo.sv | 57 +++++
 rtl/ifetch_queue.sv | 135 +++++++++++++
 tb/tb_ifetch_queue.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tta_pkg.sv
// Shared types for the fetch front end.
//   WORD_W        : instruction and address word width (24 bits)
//   word_t        : one 24-bit word
//   RESET_PC      : default first fetch address after reset
//   fetch_entry_t : queue entry holding an instruction word and its address
package tta_pkg;

  localparam int WORD_W = 24;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC = 24'h000000;

  typedef struct packed {
    word_t addr;
    word_t data;
  } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous in-order FIFO of fetch entries.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : empties the FIFO; wins over push and pop in the same cycle
//   push        : write push_entry at the tail
//   push_entry  : entry to write
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry (stale contents when count is zero)
//   count       : number of valid entries, 0..DEPTH
module ifq_fifo
  import tta_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  // DEPTH is a power of two, so the pointers wrap naturally.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the top never presents head while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between instruction memory and the core.
// Issues sequential word reads, keeps returned words with their addresses
// in an in-order FIFO, and flushes on a redirect from the core. Responses to
// requests issued before a redirect are counted in 'drop' and discarded.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   redirect          : one-cycle flush pulse, new PC in redirect_addr
//   redirect_addr     : new fetch address
//   mem_req/mem_addr  : memory read request and word address
//   mem_gnt           : request accepted this cycle
//   mem_rvalid/rdata  : in-order read response
//   instr_valid/data/addr : queue head toward the core
//   instr_ready       : core consumes the head
// Build option:
//   IFQ_BYPASS_EN     : when defined, a response arriving at an empty queue
//                       is presented to the core in the same cycle.
module ifetch_queue
  import tta_pkg::*;
#(
  parameter int    DEPTH      = 4,
  parameter word_t RESET_ADDR = RESET_PC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  redirect,
  input  word_t redirect_addr,
  output logic  mem_req,
  output word_t mem_addr,
  input  logic  mem_gnt,
  input  logic  mem_rvalid,
  input  word_t mem_rdata,
  output logic  instr_valid,
  output word_t instr_data,
  output word_t instr_addr,
  input  logic  instr_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // live + drop never exceeds 2*DEPTH-1.
  localparam int OUT_W = $clog2(2 * DEPTH);
  localparam int OCC_W = OUT_W + 1;

  word_t            fetch_addr;
  logic [OUT_W-1:0] live;
  logic [OUT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0] occupancy;

  fetch_entry_t fifo_head;
  fetch_entry_t resp_entry;
  fetch_entry_t head_entry;
  fetch_entry_t last_entry;

  logic grant;
  logic resp_keep;
  logic resp_drop;
  logic bypass_hit;
  logic pop_fire;
  logic fifo_push;
  logic fifo_pop;

  // Slots already holding a word plus slots reserved by live requests;
  // reserving at grant time is what keeps pushes from overflowing.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(live);

  assign mem_req  = !rst && !redirect && (occupancy < OCC_W'(DEPTH));
  assign mem_addr = fetch_addr;
  assign grant    = mem_req && mem_gnt;

  assign resp_keep = mem_rvalid && (drop == '0);
  assign resp_drop = mem_rvalid && (drop != '0);

  // Live requests are the contiguous addresses just below fetch_addr, so
  // the oldest one (the response now returning) sits 'live' words back.
  assign resp_entry.addr = fetch_addr - WORD_W'(live);
  assign resp_entry.data = mem_rdata;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = (fifo_count == '0) && resp_keep && !redirect && !rst;
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_entry  = bypass_hit ? resp_entry : fifo_head;
  assign instr_valid = !rst && !redirect && ((fifo_count != '0) || bypass_hit);
  assign pop_fire    = instr_valid && instr_ready;

  // A bypassed word that the core takes immediately never enters the FIFO.
  assign fifo_pop  = pop_fire && !bypass_hit;
  assign fifo_push = resp_keep && !redirect && !(bypass_hit && instr_ready);

  assign instr_addr = instr_valid ? head_entry.addr : last_entry.addr;
  assign instr_data = instr_valid ? head_entry.data : last_entry.data;

  // Redirect beats grant/response/pop: every outstanding request, including
  // one answered this very cycle, is moved to the discard count.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr <= RESET_ADDR;
      live       <= '0;
      drop       <= '0;
    end else if (redirect) begin
      fetch_addr <= redirect_addr;
      live       <= '0;
      drop       <= drop + live - OUT_W'(mem_rvalid);
    end else begin
      if (grant) fetch_addr <= fetch_addr + 1'b1;
      live <= live + OUT_W'(grant) - OUT_W'(resp_keep);
      drop <= drop - OUT_W'(resp_drop);
    end
  end

  // Holds the last presented word so the outputs stay put while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_entry <= '0;
    end else if (instr_valid) begin
      last_entry <= head_entry;
    end
  end

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (fifo_push),
    .push_entry (resp_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
`timescale 1ns/1ps
module tb_ifetch_queue;
  import tta_pkg::*;

  localparam int    DEPTH      = 4;
  localparam word_t RESET_ADDR = 24'h000000;
`ifdef IFQ_BYPASS_EN
  localparam int FIRST_VALID_CYC = 1;
`else
  localparam int FIRST_VALID_CYC = 2;
`endif

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  redirect = 1'b0;
  word_t redirect_addr = '0;
  logic  mem_req;
  word_t mem_addr;
  logic  mem_gnt = 1'b0;
  logic  mem_rvalid = 1'b0;
  word_t mem_rdata = '0;
  logic  instr_valid;
  word_t instr_data;
  word_t instr_addr;
  logic  instr_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit lat_rand = 0;
  int gnt_mode = 1;
  int grant_count = 0;
  int pop_count = 0;
  word_t pend_addr[$];
  int    pend_due[$];
  word_t exp_addr = RESET_ADDR;

  ifetch_queue #(
    .DEPTH(DEPTH),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_addr    (instr_addr),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic word_t mem_data(input word_t a);
    return {a[11:0], a[23:12]} ^ 24'h5A5A5A;
  endfunction

  // Memory model: in-order responses, latency >= 1 cycle after grant.
  always @(negedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
    end else begin
      mem_gnt = (gnt_mode == 1) ? 1'b1 :
                (gnt_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_data(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
      #1;
      if (mem_req && mem_gnt) begin
        pend_addr.push_back(mem_addr);
        pend_due.push_back(cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat));
        grant_count++;
      end
    end
  end

  // Reference address model: every consumed word must be the next expected
  // address in program order, carrying that address's memory contents.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      exp_addr = RESET_ADDR;
    end else begin
      if (redirect) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL redirect_valid: instr_valid=%b required 0", instr_valid);
        end
        exp_addr = redirect_addr;
      end else if (instr_valid && instr_ready) begin
        checks++;
        pop_count++;
        if (instr_addr !== exp_addr || instr_data !== mem_data(exp_addr)) begin
          errors++;
          $display("[TB] FAIL pop_order: addr=%h data=%h required addr=%h data=%h",
                   instr_addr, instr_data, exp_addr, mem_data(exp_addr));
        end
        exp_addr = exp_addr + 1'b1;
      end
      checks++;
      if (dut.fifo_count > DEPTH || pend_addr.size() > 2 * DEPTH - 1) begin
        errors++;
        $display("[TB] FAIL occupancy: count=%0d outstanding=%0d required <=%0d and <=%0d",
                 dut.fifo_count, pend_addr.size(), DEPTH, 2 * DEPTH - 1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a falling edge; returns at +3 of the first cycle with instr_valid.
  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #3;
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    checks += 5;
    if (mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req: mem_req=%b required 0", mem_req);
    end
    if (instr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: instr_valid=%b required 0", instr_valid);
    end
    if (instr_data !== '0) begin
      errors++; $display("[TB] FAIL reset_data: instr_data=%h required 0", instr_data);
    end
    if (instr_addr !== '0) begin
      errors++; $display("[TB] FAIL reset_addr: instr_addr=%h required 0", instr_addr);
    end
    if (mem_addr !== RESET_ADDR) begin
      errors++; $display("[TB] FAIL reset_fetch: mem_addr=%h required %h", mem_addr, RESET_ADDR);
    end
    @(negedge clk);
    rst = 1'b0;
    gnt_mode = 1;
    #3;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_ADDR) begin
      errors++;
      $display("[TB] FAIL first_req: mem_req=%b mem_addr=%h required 1 %h", mem_req, mem_addr, RESET_ADDR);
    end
  endtask

  task automatic test_latency();
    int first;
    lat = 1; gnt_mode = 1;
    do_reset();
    first = -1;
    for (int i = 0; i < 10; i++) begin
      #3;
      if (instr_valid) begin
        first = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (first != FIRST_VALID_CYC || instr_addr !== RESET_ADDR) begin
      errors++;
      $display("[TB] FAIL latency: first valid cycle=%0d addr=%h required %0d %h",
               first, instr_addr, FIRST_VALID_CYC, RESET_ADDR);
    end
  endtask

  task automatic test_stream();
    bit found;
    lat = 1; gnt_mode = 1;
    do_reset();
    instr_ready = 1'b1;
    wait_valid(20, found);
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL stream_start: no instr_valid within 20 cycles, required one");
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_addr !== word_t'(k)) begin
          errors++;
          $display("[TB] FAIL stream_seq: valid=%b addr=%h required 1 %h", instr_valid, instr_addr, word_t'(k));
        end
        @(negedge clk);
        #3;
      end
    end
  endtask

  task automatic test_stall();
    int g0;
    lat = 1; gnt_mode = 1;
    do_reset();
    g0 = grant_count;
    repeat (12) @(negedge clk);
    #3;
    checks += 3;
    if (grant_count - g0 != DEPTH) begin
      errors++; $display("[TB] FAIL stall_grants: grants=%0d required %0d", grant_count - g0, DEPTH);
    end
    if (mem_req !== 1'b0 || dut.fifo_count != DEPTH) begin
      errors++;
      $display("[TB] FAIL stall_full: mem_req=%b count=%0d required 0 %0d", mem_req, dut.fifo_count, DEPTH);
    end
    if (instr_valid !== 1'b1 || instr_addr !== 24'h000000) begin
      errors++; $display("[TB] FAIL stall_head: valid=%b addr=%h required 1 000000", instr_valid, instr_addr);
    end
    @(negedge clk);
    instr_ready = 1'b1;
    #3;
    checks++;
    if (mem_addr !== 24'h000004) begin
      errors++; $display("[TB] FAIL stall_resume_addr: mem_addr=%h required 000004", mem_addr);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== word_t'(k)) begin
        errors++;
        $display("[TB] FAIL stall_drain: valid=%b addr=%h required 1 %h", instr_valid, instr_addr, word_t'(k));
      end
      @(negedge clk);
      #3;
    end
  endtask

  task automatic test_redirect();
    bit found;
    lat = 3; gnt_mode = 1;
    do_reset();
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 24'h000100;
    #3;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("[TB] FAIL redirect_req: mem_req=%b required 0", mem_req);
    end
    @(negedge clk);
    redirect = 1'b0;
    wait_valid(20, found);
    checks++;
    if (!found || instr_addr !== 24'h000100 || instr_data !== mem_data(24'h000100)) begin
      errors++;
      $display("[TB] FAIL redirect_first: found=%b addr=%h data=%h required 1 000100 %h",
               found, instr_addr, instr_data, mem_data(24'h000100));
    end
  endtask

  task automatic test_wrap();
    bit found;
    word_t wrap_exp [4];
    wrap_exp = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    lat = 1; gnt_mode = 1;
    do_reset();
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 24'hFFFFFE;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid(20, found);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!found || instr_valid !== 1'b1 || instr_addr !== wrap_exp[k]) begin
        errors++;
        $display("[TB] FAIL wrap_seq: valid=%b addr=%h required 1 %h", instr_valid, instr_addr, wrap_exp[k]);
      end
      @(negedge clk);
      #3;
    end
  endtask

  task automatic test_redirect_pop();
    bit found;
    lat = 1; gnt_mode = 1;
    do_reset();
    instr_ready = 1'b1;
    repeat (6) @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 24'h000200;
    #3;
    checks++;
    if (instr_valid !== 1'b0 || mem_rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rdpop_cycle: instr_valid=%b rvalid=%b required 0 1", instr_valid, mem_rvalid);
    end
    @(negedge clk);
    redirect = 1'b0;
    #3;
    checks++;
    if (dut.fifo_count != 0) begin
      errors++; $display("[TB] FAIL rdpop_flush: count=%0d required 0", dut.fifo_count);
    end
    @(negedge clk);
    wait_valid(20, found);
    checks++;
    if (!found || instr_addr !== 24'h000200 || instr_data !== mem_data(24'h000200)) begin
      errors++;
      $display("[TB] FAIL rdpop_next: found=%b addr=%h required 1 000200", found, instr_addr);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    lat = 2; gnt_mode = 1;
    do_reset();
    instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 24'h000300;
    @(negedge clk);
    redirect_addr = 24'h000400;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid(20, found);
    checks++;
    if (!found || instr_addr !== 24'h000400) begin
      errors++;
      $display("[TB] FAIL b2b_target: found=%b addr=%h required 1 000400", found, instr_addr);
    end
  endtask

  task automatic test_midrun_reset();
    bit found;
    lat = 3; gnt_mode = 1;
    do_reset();
    instr_ready = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #3;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: mem_req=%b valid=%b required 0 0", mem_req, instr_valid);
    end
    @(negedge clk);
    #3;
    checks++;
    if (instr_addr !== '0 || instr_data !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: addr=%h data=%h required 0 0", instr_addr, instr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_valid(20, found);
    checks++;
    if (!found || instr_addr !== RESET_ADDR) begin
      errors++;
      $display("[TB] FAIL midrst_restart: found=%b addr=%h required 1 %h", found, instr_addr, RESET_ADDR);
    end
  endtask

  task automatic test_random();
    int p0;
    lat = 1; gnt_mode = 2; lat_rand = 1'b1;
    do_reset();
    p0 = pop_count;
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 29) == 0) begin
        redirect = 1'b1;
        redirect_addr = ($urandom_range(0, 1) == 1) ? word_t'(24'hFFFFFC + $urandom_range(0, 3))
                                                    : word_t'($urandom);
      end else begin
        redirect = 1'b0;
      end
      @(negedge clk);
    end
    redirect = 1'b0;
    lat_rand = 1'b0;
    gnt_mode = 1;
    checks++;
    if (pop_count - p0 < 50) begin
      errors++; $display("[TB] FAIL random_progress: pops=%0d required >=50", pop_count - p0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_redirect_pop();
    test_back_to_back();
    test_midrun_reset();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at 500000 ns, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
